// File: rtl/reloj_pkg.sv
// reloj_pkg: field selects, BCD limits, reset values and BCD helpers shared by the clock.
package reloj_pkg;
  localparam logic [1:0] SEL_SEC = 2'd0;
  localparam logic [1:0] SEL_MIN = 2'd1;
  localparam logic [1:0] SEL_HR = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;
  localparam logic [2:0] MAX_TENS_60 = 3'd5;
  localparam logic [3:0] MAX_UNITS = 4'd9;
  localparam logic [1:0] RST24_HD = 2'd0;
  localparam logic [3:0] RST24_HU = 4'd0;
  localparam logic [1:0] RST12_HD = 2'd1;
  localparam logic [3:0] RST12_HU = 4'd2;
  function automatic logic [6:0] bin2bcd(input logic [5:0] v);
    return {3'(v / 6'd10), 4'(v % 6'd10)};
  endfunction
  function automatic logic [5:0] bcd2bin(input logic [2:0] t, input logic [3:0] u);
    return 6'(t) * 6'd10 + 6'(u);
  endfunction
endpackage

// File: rtl/reloj_bcd60.sv
// reloj_bcd60: two-digit 00..59 BCD counter; carry flags an inc that wraps 59 to 00.
module reloj_bcd60 import reloj_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] u,
  output logic [2:0] d,
  output logic       carry
);
  logic [3:0] u_q, u_d;
  logic [2:0] d_q, d_d;
  logic up, dn;
  always_comb begin
    up = inc & ~dec;
    dn = dec & ~inc;
    carry = up && d_q == MAX_TENS_60 && u_q == MAX_UNITS;
    u_d = up ? (u_q == MAX_UNITS ? 4'd0 : u_q + 4'd1) : dn ? (u_q == 4'd0 ? MAX_UNITS : u_q - 4'd1) : u_q;
    d_d = (up && u_q == MAX_UNITS) ? (d_q == MAX_TENS_60 ? 3'd0 : d_q + 3'd1) :
          (dn && u_q == 4'd0) ? (d_q == 3'd0 ? MAX_TENS_60 : d_q - 3'd1) : d_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      u_q <= '0;
      d_q <= '0;
    end else begin
      u_q <= u_d;
      d_q <= d_d;
    end
  end
  assign u = u_q;
  assign d = d_q;
endmodule

// File: rtl/reloj_hms.sv
// reloj_hms: BCD HH:MM:SS clock with prescaler, 12/24h format and field setting.
// Optional alarm compiled in with RELOJ_ALARM_EN.
module reloj_hms import reloj_pkg::*; #(
  parameter int DIV = 1,
  parameter int MODE12 = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       set_en,
  input  logic [1:0] set_sel,
  input  logic       set_up,
  input  logic       set_dn,
  output logic [3:0] su,
  output logic [2:0] sd,
  output logic [3:0] mu,
  output logic [2:0] md,
  output logic [3:0] hu,
  output logic [1:0] hd,
  output logic       pm,
  output logic       day_pulse
`ifdef RELOJ_ALARM_EN
  ,
  input  logic       alarm_wr,
  input  logic [4:0] alarm_h,
  input  logic [5:0] alarm_m,
  output logic       alarm_hit
`endif
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(DIV - 1);
  localparam bit M12 = MODE12 != 0;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0] hd_q, hd_d;
  logic [3:0] hu_q, hu_d;
  logic pm_q, pm_d, day_q, day_d;
  logic adv, step, s_inc, s_dec, m_inc, m_dec, s_carry, m_carry, hr_adv, hr_up, hr_dn;
  logic [5:0] hb;
  logic [4:0] idx, idx_n, h12, hv;
  assign adv = tick & ~set_en & (pcnt_q == PLAST);
  assign pcnt_d = (set_en | adv) ? '0 : pcnt_q + PW'(tick);
  assign step = set_en & (set_up ^ set_dn);
  assign s_inc = adv | (step & set_up & (set_sel == SEL_SEC));
  assign s_dec = step & set_dn & (set_sel == SEL_SEC);
  // Seconds carry only cascades on a real advance; set steps wrap in-field.
  assign m_inc = (adv & s_carry) | (step & set_up & (set_sel == SEL_MIN));
  assign m_dec = step & set_dn & (set_sel == SEL_MIN);
  assign hr_adv = adv & m_carry;
  assign hr_up = hr_adv | (step & set_up & (set_sel == SEL_HR));
  assign hr_dn = step & set_dn & (set_sel == SEL_HR);
  reloj_bcd60 u_sec (.clk(clk), .rst(rst), .inc(s_inc), .dec(s_dec), .u(su), .d(sd), .carry(s_carry));
  reloj_bcd60 u_min (.clk(clk), .rst(rst), .inc(m_inc), .dec(m_dec), .u(mu), .d(md), .carry(m_carry));
  // Hours run on a 0..23 index (0 = midnight) so both formats share one stepper.
  always_comb begin
    hb = bcd2bin({1'b0, hd_q}, hu_q);
    idx = M12 ? 5'(hb == 6'd12 ? 6'd0 : hb) + (pm_q ? 5'd12 : 5'd0) : 5'(hb);
    idx_n = hr_up ? (idx == 5'd23 ? 5'd0 : idx + 5'd1) : hr_dn ? (idx == 5'd0 ? 5'd23 : idx - 5'd1) : idx;
    h12 = idx_n % 5'd12;
    hv = M12 ? (h12 == 5'd0 ? 5'd12 : h12) : idx_n;
    hd_d = 2'(hv / 5'd10);
    hu_d = 4'(hv % 5'd10);
    pm_d = M12 && idx_n >= 5'd12;
    day_d = hr_adv && idx == 5'd23;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
      hd_q <= M12 ? RST12_HD : RST24_HD;
      hu_q <= M12 ? RST12_HU : RST24_HU;
      pm_q <= 1'b0;
      day_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      hd_q <= hd_d;
      hu_q <= hu_d;
      pm_q <= pm_d;
      day_q <= day_d;
    end
  end
  assign hd = hd_q;
  assign hu = hu_q;
  assign pm = pm_q;
  assign day_pulse = day_q;
`ifdef RELOJ_ALARM_EN
  logic [1:0] ahd_q, ahd_d;
  logic [3:0] ahu_q, ahu_d, amu_q, amu_d;
  logic [2:0] amd_q, amd_d;
  logic hit_q, hit_d;
  logic [4:0] ah;
  logic [5:0] am, mn;
  logic [6:0] amb, mnb;
  always_comb begin
    ah = alarm_h > 5'd23 ? 5'd23 : alarm_h;
    am = alarm_m > 6'd59 ? 6'd59 : alarm_m;
    amb = bin2bcd(am);
    ahd_d = alarm_wr ? 2'(ah / 5'd10) : ahd_q;
    ahu_d = alarm_wr ? 4'(ah % 5'd10) : ahu_q;
    amd_d = alarm_wr ? amb[6:4] : amd_q;
    amu_d = alarm_wr ? amb[3:0] : amu_q;
    mn = m_carry ? 6'd0 : bcd2bin(md, mu) + 6'd1;
    mnb = bin2bcd(mn);
    hit_d = adv && s_carry && mnb == {amd_q, amu_q} && {2'(idx_n / 5'd10), 4'(idx_n % 5'd10)} == {ahd_q, ahu_q};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ahd_q <= '0;
      ahu_q <= '0;
      amd_q <= '0;
      amu_q <= '0;
      hit_q <= 1'b0;
    end else begin
      ahd_q <= ahd_d;
      ahu_q <= ahu_d;
      amd_q <= amd_d;
      amu_q <= amu_d;
      hit_q <= hit_d;
    end
  end
  assign alarm_hit = hit_q;
`endif
endmodule

// File: doc/reloj_hms.md
# reloj_hms

Parametrised BCD time-of-day counter (HH:MM:SS) with a built-in second prescaler, a selectable 12/24-hour format, and per-field up/down setting. It drives the display multiplexer directly with BCD digits. It emits a one-cycle day-rollover pulse for a downstream date/day counter. It supersedes the fixed 24-hour HH:MM counter, which only set fields upward, had no seconds output and had no working reset.

## Interface

Parameters:
- `DIV`, default 1: `tick` pulses per second; 1 means every `tick` advances one second.
- `MODE12`, default 0: 0 gives 24-hour format; 1 gives 12-hour format with `pm` flag.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset; synchronous and active-high.
- `tick`  in  1  single-cycle time-base enable.
- `set_en`  in  1  set mode; time advance frozen while high.
- `set_sel`  in  2  field to set: 0 seconds, 1 minutes, 2 hours, 3 none.
- `set_up`  in  1  single-cycle increment of the selected field.
- `set_dn`  in  1  single-cycle decrement of the selected field.
- `su`  out  4  seconds units (BCD).
- `sd`  out  3  seconds tens.
- `mu`  out  4  minutes units.
- `md`  out  3  minutes tens.
- `hu`  out  4  hours units.
- `hd`  out  2  hours tens.
- `pm`  out  1  PM flag; 0 when `MODE12`=0.
- `day_pulse`  out  1  one-cycle pulse on midnight rollover.

## Operation

- **Reset values.**
  - `MODE12`=0: 00:00:00, `pm`=0.
  - `MODE12`=1: 12:00:00 with `pm`=0.
  - `day_pulse`=0, prescaler=0, alarm (when compiled in) 00:00 or 12:00 AM.
- **Prescaler.** `pcnt` counts 0..DIV-1, advancing only on `tick`. A second advance (`adv`) occurs when `tick` is high and `pcnt`=DIV-1, and `pcnt` then wraps to 0. With DIV=1 every `tick` gives `adv`.
- **Normal count (`adv` and `set_en`=0).**
  - Seconds go 00..59 and carry into minutes.
  - Minutes go 00..59 and carry into hours.
  - 24-hour format: hours go 00..23, and 23:59:59 wraps to 00:00:00 with `day_pulse`=1.
  - 12-hour format: hours go 12,01..11,12. `pm` toggles on 11:59:59→12:00:00. PM-to-AM (12 AM) raises `day_pulse`.
- **Set mode (`set_en`=1).**
  - `adv` is suppressed and `pcnt` is held at 0.
  - `set_up`/`set_dn` step the selected field by ±1 and wrap within that field only: no carry, no borrow, no `day_pulse`.
  - Field ranges are 00..59 for seconds and minutes, and 00..23 for hours.
  - In 12-hour format, hours step cyclically through 24 positions: 12AM,01AM..11AM,12PM..11PM. `pm` toggles on the 11↔12 crossing.
  - `set_up` and `set_dn` together: no change. `set_sel`=3: no change.
  - `set_up`/`set_dn` are ignored when `set_en`=0.
- **Priority.** `rst` > set mode > `adv`. A `tick` during `set_en` is discarded, not queued.
- **BCD rules.** Units digits never exceed 9 and tens digits never exceed their field maximum. An out-of-range state cannot arise, since reset is the only entry point.

## Timing

- Every output is registered.
- An `adv` sampled at edge N is visible after edge N, including a full cascade such as 23:59:59→00:00:00.
- `day_pulse` is high for exactly the cycle after the rollover edge, coincident with the new time value.
- A set step is visible one cycle after the `set_up`/`set_dn` edge.
- Leaving set mode: the first `adv` needs DIV further `tick`s.
- `rst` mid-cascade: the reset values win at that edge and `day_pulse` stays 0.

## Configuration

- Macro: `RELOJ_ALARM_EN`.
- **Defined:**
  - Extra ports `alarm_wr` (in, 1), `alarm_h` (in, 5, binary 0..23) and `alarm_m` (in, 6, binary 0..59), plus `alarm_hit` (out, 1).
  - `alarm_wr` latches the alarm time, held internally as BCD. Out-of-range values are clamped to the field maximum.
  - `alarm_hit` pulses for one cycle when a normal-count `adv` produces seconds=00 with hours:minutes equal to the alarm.
  - `alarm_hit` never fires in set mode.
  - The alarm hour is always 24-hour; it is compared against the hour with `pm` resolved in 12-hour format.
- **Undefined:** the alarm ports and logic are absent, and the core behaviour is identical.

## Structure

- Package `reloj_pkg` holds:
  - field selects: `SEL_SEC`=0, `SEL_MIN`=1, `SEL_HR`=2, `SEL_NONE`=3;
  - BCD limits: `MAX_TENS_60`=5, `MAX_UNITS`=9;
  - the 24-hour and 12-hour reset-value constants.
- Sub-module `reloj_bcd60`: a two-digit 00..59 BCD counter with `inc`, `dec` and `rst` inputs and a `carry` output (carry only on an `inc` wrap). It is instantiated for seconds and minutes.
- The hours logic, prescaler, `pm` and alarm stay in the top level.

## Test plan

- **Reset:** `rst`=1 for 1 cycle with `MODE12`=0 → outputs 00:00:00, `pm`=0, `day_pulse`=0. With `MODE12`=1 → 12:00:00, `pm`=0.
- **Prescaler:** DIV=4, 8 `tick`s → time 00:00:02, with advances on the 4th and 8th `tick` only.
- **Midnight rollover:** set 23:59:59, one `adv` → 00:00:00, `day_pulse` high exactly one cycle. `MODE12`=1: 11:59:59 PM → 12:00:00 AM with pulse; 11:59:59 AM → 12:00:00 PM with `pm`=1 and no pulse.
- **Set wrap:** `set_en`=1, `set_sel`=1 at 00:59:30, `set_up` → 00:00:30 with hours unchanged. Then `set_dn` → 00:59:30. Both pulses together → unchanged. `tick`s during the sequence → no advance.
- **Reset mid-cascade:** `rst` asserted on the same edge as 23:59:59 `adv` → 00:00:00 and `day_pulse`=0.
- **Alarm (`RELOJ_ALARM_EN`):** alarm 07:30, run from 07:29:58 → `alarm_hit` one cycle at 07:30:00 and none at 07:30:01. Repeat in set mode → no hit.
